// File: rtl/int_mult_exec_cdb.sv
// Integer/branch single-cycle execute plus fixed-latency multiply pipeline,
// merged onto one common data bus with multiply results taking priority.
module int_mult_exec_cdb #(
    parameter int MULT_LAT = 3,
    parameter int TAG_W    = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_int_empty,
    input  logic [6:0]       i_int_opcode,
    input  logic [2:0]       i_int_func3,
    input  logic [6:0]       i_int_func7,
    input  logic [31:0]      i_int_rs1_data,
    input  logic [31:0]      i_int_rs2_data,
    input  logic [TAG_W-1:0] i_int_rd_tag,
    output logic             o_int_rd,
    input  logic             i_mult_empty,
    input  logic [31:0]      i_mult_rs1_data,
    input  logic [31:0]      i_mult_rs2_data,
    input  logic [TAG_W-1:0] i_mult_rd_tag,
    output logic             o_mult_rd,
    output logic             o_cdb_valid,
    output logic [TAG_W-1:0] o_cdb_tag,
    output logic [31:0]      o_cdb_data,
    output logic             o_cdb_branch,
    output logic             o_cdb_branch_taken
);
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    logic             w_last_v;
    logic [TAG_W-1:0] w_last_tag;
    logic [31:0]      w_last_prod;
    logic [31:0]      w_prod;
    logic             w_int_pop;
    logic             w_bcast;
    logic             w_br;
    logic             w_taken;
    logic [31:0]      w_res;

    assign o_mult_rd = !i_mult_empty && !i_rst;
    assign w_prod    = i_mult_rs1_data * i_mult_rs2_data;

    // w_last_* is the multiply that will own the bus at the next edge.
    generate
        if (MULT_LAT == 1) begin : g_lat1
            assign w_last_v    = o_mult_rd;
            assign w_last_tag  = i_mult_rd_tag;
            assign w_last_prod = w_prod;
        end else begin : g_pipe
            logic             r_v    [1:MULT_LAT-1];
            logic [TAG_W-1:0] r_tag  [1:MULT_LAT-1];
            logic [31:0]      r_prod [1:MULT_LAT-1];

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int k = 1; k < MULT_LAT; k++) begin
                        r_v[k]    <= 1'b0;
                        r_tag[k]  <= '0;
                        r_prod[k] <= '0;
                    end
                end else begin
                    r_v[1]    <= o_mult_rd;
                    r_tag[1]  <= i_mult_rd_tag;
                    r_prod[1] <= w_prod;
                    for (int k = 2; k < MULT_LAT; k++) begin
                        r_v[k]    <= r_v[k-1];
                        r_tag[k]  <= r_tag[k-1];
                        r_prod[k] <= r_prod[k-1];
                    end
                end
            end

            assign w_last_v    = r_v[MULT_LAT-1];
            assign w_last_tag  = r_tag[MULT_LAT-1];
            assign w_last_prod = r_prod[MULT_LAT-1];
        end
    endgenerate

    assign o_int_rd  = !i_int_empty && !w_last_v && !i_rst;
    assign w_int_pop = o_int_rd;

    always_comb begin
        w_res   = 32'd0;
        w_bcast = 1'b0;
        w_br    = 1'b0;
        w_taken = 1'b0;
        case (i_int_opcode)
            OP_R: begin
                w_bcast = 1'b1;
                if (i_int_func7 == 7'h00) begin
                    case (i_int_func3)
                        3'd0:    w_res = i_int_rs1_data + i_int_rs2_data;
                        3'd4:    w_res = i_int_rs1_data ^ i_int_rs2_data;
                        3'd6:    w_res = i_int_rs1_data | i_int_rs2_data;
                        3'd7:    w_res = i_int_rs1_data & i_int_rs2_data;
                        default: w_res = 32'd0;
                    endcase
                end else if (i_int_func7 == 7'h20 && i_int_func3 == 3'd0) begin
                    w_res = i_int_rs1_data - i_int_rs2_data;
                end
            end
            OP_I: begin
                w_bcast = 1'b1;
                case (i_int_func3)
                    3'd0:    w_res = i_int_rs1_data + i_int_rs2_data;
                    3'd4:    w_res = i_int_rs1_data ^ i_int_rs2_data;
                    3'd6:    w_res = i_int_rs1_data | i_int_rs2_data;
                    3'd7:    w_res = i_int_rs1_data & i_int_rs2_data;
                    default: w_res = 32'd0;
                endcase
            end
            OP_LUI: begin
                w_bcast = 1'b1;
                w_res   = i_int_rs2_data;
            end
            OP_BR: begin
                w_br = 1'b1;
                case (i_int_func3)
                    3'd0:    w_taken = (i_int_rs1_data == i_int_rs2_data);
                    3'd1:    w_taken = (i_int_rs1_data != i_int_rs2_data);
                    3'd4:    w_taken = ($signed(i_int_rs1_data) <  $signed(i_int_rs2_data));
                    3'd5:    w_taken = ($signed(i_int_rs1_data) >= $signed(i_int_rs2_data));
                    3'd6:    w_taken = (i_int_rs1_data <  i_int_rs2_data);
                    3'd7:    w_taken = (i_int_rs1_data >= i_int_rs2_data);
                    default: w_taken = 1'b0;
                endcase
            end
            7'd0:    w_bcast = 1'b0;
            default: w_bcast = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cdb_valid        <= 1'b0;
            o_cdb_tag          <= '0;
            o_cdb_data         <= '0;
            o_cdb_branch       <= 1'b0;
            o_cdb_branch_taken <= 1'b0;
        end else begin
            o_cdb_valid        <= 1'b0;
            o_cdb_branch       <= 1'b0;
            o_cdb_branch_taken <= 1'b0;
            if (w_last_v) begin
                o_cdb_valid <= 1'b1;
                o_cdb_tag   <= w_last_tag;
                o_cdb_data  <= w_last_prod;
            end else if (w_int_pop) begin
                if (w_bcast) begin
                    o_cdb_valid <= 1'b1;
                    o_cdb_tag   <= i_int_rd_tag;
                    o_cdb_data  <= w_res;
                end
                if (w_br) begin
                    o_cdb_branch       <= 1'b1;
                    o_cdb_branch_taken <= w_taken;
                end
            end
        end
    end
endmodule
